lzma2_job_controller: RTL and testbench
=======================================

# lzma2_job_controller

Multi-channel successor to the single-job system controller. Arbitrates up to NUM_CH job requesters onto the one shared compression engine, sequences each job through grant/run/verify/report, and enforces a programmable total timeout and an inactivity (stall) watchdog. Reports per-job error codes and keeps saturating job statistics. Sits between the host-facing channel logic and `lzma2_compression_engine`/CRC checker inside `lzma2_top`.

## Interface
- NUM_CH, 4: number of requesting channels (1..16)
- TMO_W, 32: width of total-timeout counter/limit
- STALL_W, 16: width of stall counter/limit
- STAT_W, 16: width of job statistics counters
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req  in  NUM_CH  per-channel job request; level, held until ack
- ack  out  NUM_CH  one-cycle grant pulse, one-hot
- done  out  NUM_CH  one-cycle job-finished pulse, one-hot
- err_code  out  4  ctrl_err_t of finished job; valid only while any done bit is high, else 0
- abort  in  1  abort the current job
- timeout_limit  in  TMO_W  max cycles from GRANT to REPORT; 0 disables
- stall_limit  in  STALL_W  max consecutive beat-free cycles in RUN; 0 disables
- eng_sel  out  $clog2(NUM_CH) (min 1)  granted channel index, stable GRANT through REPORT
- eng_start  out  1  one-cycle engine start pulse
- in_valid, in_ready  in  1 each  engine input handshake, monitored only
- out_valid, out_ready, out_last  in  1 each  engine output handshake, monitored only
- crc_valid, crc_match  in  1 each  CRC checker result
- busy  out  1  high in any state other than IDLE
- state  out  3  current ctrl_state_t
- jobs_ok, jobs_err  out  STAT_W each  saturating completed/failed job counts

## Operation
- States: IDLE, GRANT, RUN, VERIFY, REPORT.
- IDLE: if any req, pick channel via round-robin starting at rr_ptr; latch into eng_sel; -> GRANT. abort ignored.
- GRANT: ack[sel]=1, eng_start=1, clear tmo_cnt and stall_cnt; -> RUN; if abort -> REPORT with ERR_ABORT.
- RUN: tmo_cnt+1 each cycle; beat = (in_valid&in_ready)|(out_valid&out_ready); beat clears stall_cnt, else stall_cnt+1. Exit priority, highest first: abort -> ERR_ABORT; output beat with out_last -> VERIFY; tmo_cnt+1 == timeout_limit -> ERR_TIMEOUT; stall_cnt+1 == stall_limit -> ERR_STALL; error exits -> REPORT.
- VERIFY: tmo_cnt keeps counting, stall counter frozen. Priority: abort; crc_valid -> REPORT with crc_match ? ERR_NONE : ERR_CRC; timeout.
- REPORT: done[sel]=1, err_code driven; jobs_ok or jobs_err +1, saturating at all-ones; rr_ptr <= sel+1 mod NUM_CH; -> IDLE.
- Counters: tmo_cnt and stall_cnt saturate at all-ones; they never wrap, so a limit equal to all-ones is still reachable.
- Reset: state IDLE, rr_ptr 0, all outputs and counters 0.
- Limits are sampled every cycle; a limit change mid-job takes effect immediately.
- A req dropped before GRANT is simply not granted. req for the active channel is ignored until REPORT.

## Timing
- req high at IDLE cycle n -> ack/eng_start at n+1.
- Last output beat at cycle m -> VERIFY at m+1.
- crc_valid at cycle k in VERIFY -> done at k+1, IDLE at k+2; a pending req is granted at k+3.
- timeout_limit=L: job with no last beat reaches REPORT exactly L cycles after the GRANT cycle.
- stall_limit=S: REPORT occurs S+1 cycles after the last beat, or S+1 cycles after GRANT if there were no beats.
- All outputs are registered, except ack, done, eng_start and err_code, which are decoded from the registered state and sel.

## Structure
- lzma2_pkg gains ctrl_state_t (3-bit enum) and ctrl_err_t: ERR_NONE=0, ERR_TIMEOUT=1, ERR_STALL=2, ERR_CRC=3, ERR_ABORT=4.
- Sub-module lzma2_rr_arbiter, parameter N: inputs req, ptr; outputs gnt_idx, gnt_valid. Purely combinational rotate-and-priority-encode.

## Test plan
- NUM_CH=4, req=4'b1010 held, every job ends with last beat and crc_match=1 -> grants ch1, ch3, ch1, …; jobs_ok increments per job; err_code 0.
- timeout_limit=100, stall_limit=0, no last beat -> done exactly 100 cycles after the ack cycle, err_code 1, jobs_err=1.
- stall_limit=10, in-beats every 5 cycles then none -> done 11 cycles after the final beat, err_code 2.
- Last beat and abort in the same cycle -> err_code 4; last beat and timeout in the same cycle -> VERIFY.
- crc_valid=1, crc_match=0 -> err_code 3. Assert rst mid-RUN -> next cycle state=0, busy=0, counters=0, rr restarts at ch0.
- Force jobs_ok to all-ones, then run another good job -> jobs_ok stays 16'hFFFF.

Source files
------------

// File: rtl/lzma2_pkg.sv
// Shared types for the LZMA2 controller slice: job FSM states, job error codes
// and a width helper used for channel-index ports.
package lzma2_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GRANT  = 3'd1,
    S_RUN    = 3'd2,
    S_VERIFY = 3'd3,
    S_REPORT = 3'd4
  } ctrl_state_t;

  typedef enum logic [3:0] {
    ERR_NONE    = 4'd0,
    ERR_TIMEOUT = 4'd1,
    ERR_STALL   = 4'd2,
    ERR_CRC     = 4'd3,
    ERR_ABORT   = 4'd4
  } ctrl_err_t;

  // Index width for n channels, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lzma2_rr_arbiter.sv
// Combinational round-robin arbiter: scans requests starting at ptr and
// returns the first asserted index.
module lzma2_rr_arbiter
  import lzma2_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_valid
);

  // NOTE: every always_comb output gets a default before any branch, so no
  // path can leave it holding its old value and infer a latch.
  always_comb begin
    logic [IW-1:0] idx;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = '0;
    for (int i = 0; i < N; i++) begin
      idx = IW'((int'(ptr) + i) % N);
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/lzma2_job_controller.sv
// Arbitrates NUM_CH job requesters onto the shared compression engine and
// sequences each job through grant/run/verify/report with timeout and stall guards.
module lzma2_job_controller
  import lzma2_pkg::*;
#(
  parameter  int NUM_CH  = 4,
  parameter  int TMO_W   = 32,
  parameter  int STALL_W = 16,
  parameter  int STAT_W  = 16,
  localparam int SEL_W   = clog2_min1(NUM_CH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_CH-1:0]  req,
  output logic [NUM_CH-1:0]  ack,
  output logic [NUM_CH-1:0]  done,
  output logic [3:0]         err_code,
  input  logic               abort,
  input  logic [TMO_W-1:0]   timeout_limit,
  input  logic [STALL_W-1:0] stall_limit,
  output logic [SEL_W-1:0]   eng_sel,
  output logic               eng_start,
  input  logic               in_valid,
  input  logic               in_ready,
  input  logic               out_valid,
  input  logic               out_ready,
  input  logic               out_last,
  input  logic               crc_valid,
  input  logic               crc_match,
  output logic               busy,
  output logic [2:0]         state,
  output logic [STAT_W-1:0]  jobs_ok,
  output logic [STAT_W-1:0]  jobs_err
);

  ctrl_state_t        state_q, state_d;
  ctrl_err_t          err_q, err_d;
  logic [SEL_W-1:0]   sel_q;
  logic [SEL_W-1:0]   rr_ptr;
  logic [TMO_W-1:0]   tmo_cnt, tmo_inc;
  logic [STALL_W-1:0] stall_cnt, stall_inc;
  logic [SEL_W-1:0]   gnt_idx;
  logic               gnt_valid;
  logic               beat, last_beat, tmo_hit, stall_hit;

  lzma2_rr_arbiter #(.N(NUM_CH), .IW(SEL_W)) u_arb (
    .req       (req),
    .ptr       (rr_ptr),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  assign beat      = (in_valid & in_ready) | (out_valid & out_ready);
  assign last_beat = out_valid & out_ready & out_last;
  assign tmo_inc   = (&tmo_cnt) ? tmo_cnt : tmo_cnt + TMO_W'(1);
  assign stall_inc = (&stall_cnt) ? stall_cnt : stall_cnt + STALL_W'(1);

  // Compare against the unsaturated increment so an all-ones limit still hits.
  assign tmo_hit   = (timeout_limit != '0) && (tmo_cnt + TMO_W'(1) == timeout_limit);
  assign stall_hit = (stall_limit != '0) && !beat && (stall_cnt + STALL_W'(1) == stall_limit);

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE:   if (gnt_valid) state_d = S_GRANT;
      S_GRANT: begin
        if (abort) begin
          state_d = S_REPORT;
          err_d   = ERR_ABORT;
        end else begin
          state_d = S_RUN;
          err_d   = ERR_NONE;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_REPORT;
          err_d   = ERR_ABORT;
        end else if (last_beat) begin
          state_d = S_VERIFY;
        end else if (tmo_hit) begin
          state_d = S_REPORT;
          err_d   = ERR_TIMEOUT;
        end else if (stall_hit) begin
          state_d = S_REPORT;
          err_d   = ERR_STALL;
        end
      end
      S_VERIFY: begin
        if (abort) begin
          state_d = S_REPORT;
          err_d   = ERR_ABORT;
        end else if (crc_valid) begin
          state_d = S_REPORT;
          err_d   = crc_match ? ERR_NONE : ERR_CRC;
        end else if (tmo_hit) begin
          state_d = S_REPORT;
          err_d   = ERR_TIMEOUT;
        end
      end
      S_REPORT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign ack       = (state_q == S_GRANT)  ? (NUM_CH'(1) << sel_q) : '0;
  assign done      = (state_q == S_REPORT) ? (NUM_CH'(1) << sel_q) : '0;
  assign eng_start = (state_q == S_GRANT);
  assign err_code  = (state_q == S_REPORT) ? err_q : ERR_NONE;
  assign eng_sel   = sel_q;
  assign state     = state_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      err_q     <= ERR_NONE;
      sel_q     <= '0;
      rr_ptr    <= '0;
      tmo_cnt   <= '0;
      stall_cnt <= '0;
      busy      <= 1'b0;
      jobs_ok   <= '0;
      jobs_err  <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      busy    <= (state_d != S_IDLE);
      case (state_q)
        S_IDLE: begin
          if (gnt_valid) sel_q <= gnt_idx;
          tmo_cnt   <= '0;
          stall_cnt <= '0;
        end
        // The GRANT cycle already counts toward the total timeout, so a job
        // with limit L reaches REPORT exactly L cycles after GRANT.
        S_GRANT: begin
          tmo_cnt   <= tmo_inc;
          stall_cnt <= '0;
        end
        S_RUN: begin
          tmo_cnt   <= tmo_inc;
          stall_cnt <= beat ? '0 : stall_inc;
        end
        S_VERIFY: tmo_cnt <= tmo_inc;
        S_REPORT: begin
          if (err_q == ERR_NONE) begin
            if (!(&jobs_ok)) jobs_ok <= jobs_ok + STAT_W'(1);
          end else begin
            if (!(&jobs_err)) jobs_err <= jobs_err + STAT_W'(1);
          end
          rr_ptr <= (sel_q == SEL_W'(NUM_CH - 1)) ? '0 : sel_q + SEL_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lzma2_job_controller.sv
// Scoreboard bench for lzma2_job_controller: stimulus queues expected grants and
// completions, a negedge monitor pops and compares them as the DUT presents them.
module tb_lzma2_job_controller;

  localparam int NUM_CH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [3:0]  ack, done, err_code;
  logic        abort = 1'b0;
  logic [31:0] timeout_limit = '0;
  logic [15:0] stall_limit = '0;
  logic [1:0]  eng_sel;
  logic        eng_start;
  logic        in_valid = 1'b0, in_ready = 1'b0;
  logic        out_valid = 1'b0, out_ready = 1'b0, out_last = 1'b0;
  logic        crc_valid = 1'b0, crc_match = 1'b0;
  logic        busy;
  logic [2:0]  state;
  logic [15:0] jobs_ok, jobs_err;

  lzma2_job_controller #(.NUM_CH(NUM_CH)) dut (
    .clk(clk), .rst(rst), .req(req), .ack(ack), .done(done), .err_code(err_code),
    .abort(abort), .timeout_limit(timeout_limit), .stall_limit(stall_limit),
    .eng_sel(eng_sel), .eng_start(eng_start),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .crc_valid(crc_valid), .crc_match(crc_match),
    .busy(busy), .state(state), .jobs_ok(jobs_ok), .jobs_err(jobs_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int ch;
    int err;
    int cyc;
  } exp_t;

  exp_t ack_q[$];
  exp_t done_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: ack and done are decoded from registered state, so negedge is stable.
  exp_t m;
  always @(negedge clk) begin
    if (!rst && |ack) begin
      if (ack_q.size() == 0) check("unexpected_ack", 32'(ack), 32'd0);
      else begin
        m = ack_q.pop_front();
        check("ack_onehot", 32'(ack), 32'(1 << m.ch));
        check("ack_cycle", cyc, m.cyc);
        check("eng_start", 32'(eng_start), 32'd1);
        check("eng_sel", 32'(eng_sel), m.ch);
      end
    end
    if (!rst && |done) begin
      if (done_q.size() == 0) check("unexpected_done", 32'(done), 32'd0);
      else begin
        m = done_q.pop_front();
        check("done_onehot", 32'(done), 32'(1 << m.ch));
        check("err_code", 32'(err_code), m.err);
        check("done_cycle", cyc, m.cyc);
      end
    end
  end

  task automatic wait_state(input logic [2:0] s, input int budget);
    int n = 0;
    @(negedge clk);
    while (state !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_state", 32'(state), 32'(s));
  endtask

  task automatic wait_ack(output int a);
    int n = 0;
    @(negedge clk);
    while (ack == '0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ack_seen", 32'(|ack), 32'd1);
    a = cyc;
  endtask

  // Called at an IDLE negedge: request is seen at the next edge, grant one cycle later.
  task automatic start_job(input logic [3:0] r, input int ch);
    req = r;
    ack_q.push_back('{ch: ch, err: 0, cyc: cyc + 1});
  endtask

  task automatic do_verify_job(input bit match, input int ch, input int err,
                               input bit drop, output int dc);
    wait_state(3'd2, 20);
    out_valid = 1'b1; out_ready = 1'b1; out_last = 1'b1;
    @(negedge clk);
    out_valid = 1'b0; out_ready = 1'b0; out_last = 1'b0;
    crc_valid = 1'b1; crc_match = match;
    dc = cyc + 1;
    done_q.push_back('{ch: ch, err: err, cyc: dc});
    if (drop) req = '0;
    @(negedge clk);
    crc_valid = 1'b0; crc_match = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int a, b, dc;
    int chs[4] = '{1, 3, 1, 3};

    repeat (3) @(negedge clk);
    check("rst_state", 32'(state), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_eng_sel", 32'(eng_sel), 32'd0);
    check("rst_jobs_ok", 32'(jobs_ok), 32'd0);
    check("rst_jobs_err", 32'(jobs_err), 32'd0);
    rst = 1'b0;

    // Held req 1010: ch1, ch3, ch1, ch3, each next grant 2 cycles after done.
    start_job(4'b1010, 1);
    for (int i = 0; i < 4; i++) begin
      do_verify_job(1'b1, chs[i], 0, i == 3, dc);
      if (i < 3) ack_q.push_back('{ch: chs[i + 1], err: 0, cyc: dc + 2});
    end
    wait_state(3'd0, 10);
    check("rr_jobs_ok", 32'(jobs_ok), 32'd4);
    check("rr_jobs_err", 32'(jobs_err), 32'd0);

    // Total timeout of 100 with no last beat.
    timeout_limit = 32'd100;
    start_job(4'b0001, 0);
    wait_ack(a);
    req = '0;
    done_q.push_back('{ch: 0, err: 1, cyc: a + 100});
    wait_state(3'd0, 150);
    timeout_limit = '0;
    check("tmo_jobs_err", 32'(jobs_err), 32'd1);

    // Stall watchdog of 10 after three input beats spaced 5 cycles apart.
    stall_limit = 16'd10;
    start_job(4'b0010, 1);
    wait_ack(a);
    req = '0;
    wait_state(3'd2, 5);
    b = 0;
    for (int i = 0; i < 3; i++) begin
      repeat (4) @(negedge clk);
      in_valid = 1'b1; in_ready = 1'b1;
      b = cyc;
      @(negedge clk);
      in_valid = 1'b0; in_ready = 1'b0;
    end
    done_q.push_back('{ch: 1, err: 2, cyc: b + 11});
    wait_state(3'd0, 50);
    stall_limit = '0;
    check("stall_jobs_err", 32'(jobs_err), 32'd2);

    // Last beat together with abort: abort wins.
    start_job(4'b0100, 2);
    wait_ack(a);
    req = '0;
    wait_state(3'd2, 5);
    out_valid = 1'b1; out_ready = 1'b1; out_last = 1'b1; abort = 1'b1;
    done_q.push_back('{ch: 2, err: 4, cyc: cyc + 1});
    @(negedge clk);
    out_valid = 1'b0; out_ready = 1'b0; out_last = 1'b0; abort = 1'b0;
    wait_state(3'd0, 10);
    check("abort_jobs_err", 32'(jobs_err), 32'd3);

    // Last beat on the exact timeout cycle: job proceeds to VERIFY.
    timeout_limit = 32'd5;
    start_job(4'b1000, 3);
    wait_ack(a);
    req = '0;
    repeat (4) @(negedge clk);
    out_valid = 1'b1; out_ready = 1'b1; out_last = 1'b1;
    @(negedge clk);
    out_valid = 1'b0; out_ready = 1'b0; out_last = 1'b0;
    check("last_vs_tmo_state", 32'(state), 32'd3);
    crc_valid = 1'b1; crc_match = 1'b1;
    done_q.push_back('{ch: 3, err: 0, cyc: a + 6});
    @(negedge clk);
    crc_valid = 1'b0; crc_match = 1'b0;
    timeout_limit = '0;
    wait_state(3'd0, 10);
    check("last_vs_tmo_jobs_ok", 32'(jobs_ok), 32'd5);

    // CRC mismatch.
    start_job(4'b0011, 0);
    do_verify_job(1'b0, 0, 3, 1'b1, dc);
    wait_state(3'd0, 10);
    check("crc_jobs_err", 32'(jobs_err), 32'd4);
    check("crc_jobs_ok", 32'(jobs_ok), 32'd5);

    // Reset in the middle of RUN; rr_ptr is 1 so 0101 grants ch2 first.
    start_job(4'b0101, 2);
    wait_state(3'd2, 10);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    check("mid_rst_state", 32'(state), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_tmo_cnt", 32'(dut.tmo_cnt), 32'd0);
    check("mid_rst_stall_cnt", 32'(dut.stall_cnt), 32'd0);
    check("mid_rst_jobs_ok", 32'(jobs_ok), 32'd0);
    check("mid_rst_jobs_err", 32'(jobs_err), 32'd0);
    check("mid_rst_eng_sel", 32'(eng_sel), 32'd0);
    rst = 1'b0;
    start_job(4'b1111, 0);
    do_verify_job(1'b1, 0, 0, 1'b1, dc);
    wait_state(3'd0, 10);
    check("post_rst_jobs_ok", 32'(jobs_ok), 32'd1);

    // Saturation of the good-job counter.
    force dut.jobs_ok = 16'hFFFF;
    @(negedge clk);
    release dut.jobs_ok;
    @(negedge clk);
    check("sat_preload", 32'(jobs_ok), 32'h0000_FFFF);
    start_job(4'b0010, 1);
    do_verify_job(1'b1, 1, 0, 1'b1, dc);
    wait_state(3'd0, 10);
    check("sat_jobs_ok", 32'(jobs_ok), 32'h0000_FFFF);
    check("sat_jobs_err", 32'(jobs_err), 32'd0);

    repeat (3) @(negedge clk);
    check("ack_q_drained", ack_q.size(), 32'd0);
    check("done_q_drained", done_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
